// File: rtl/data_mem_resp.sv
// Data-side memory responder: on-chip RAM plus an MMIO window with a buffered output stream.
// Optional build macro DMEM_CYCLE_CTR_EN compiles in the free-running cycle counter at MMIO 0x2.
module data_mem_resp #(
    parameter int DEPTH_LOG2 = 8,
    parameter int FIFO_LOG2  = 2
) (
    input  logic        clk,
    input  logic        NReset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 1 << DEPTH_LOG2;
    localparam int FIFO_DEPTH = 1 << FIFO_LOG2;

    localparam logic [FIFO_LOG2:0]   CNT_ONE  = 1;
    localparam logic [FIFO_LOG2:0]   CNT_FULL = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = 1;

    localparam logic [3:0] OFF_OUTQ   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_CYCLE  = 4'h2;
    localparam logic [3:0] OFF_CLR    = 4'h3;

    logic [DATA_W-1:0]    ramMem  [RAM_DEPTH];
    logic [DATA_W-1:0]    fifoMem [FIFO_DEPTH];
    logic [FIFO_LOG2-1:0] wrPtr;
    logic [FIFO_LOG2-1:0] rdPtr;
    logic [FIFO_LOG2:0]   count;
    logic [31:0]          cycleCnt;

    logic                  mmioSel;
    logic [3:0]            mmioOff;
    logic [DEPTH_LOG2-1:0] ramIdx;
    logic                  ramWe;
    logic                  push;
    logic                  pop;
    logic                  pushAccept;
    logic                  clrWr;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [31:0]           countExt;
    logic [31:0]           statusWord;
    logic                  unusedAddrBits;

    assign mmioSel = addr[31];
    assign mmioOff = addr[3:0];
    assign ramIdx  = addr[DEPTH_LOG2-1:0];
    // Upper address bits alias by design; fold them away explicitly.
    assign unusedAddrBits = &{1'b0, addr[30:DEPTH_LOG2]};

    assign ramWe = we & ~mmioSel;
    assign push  = we & mmioSel & (mmioOff == OFF_OUTQ);
    assign clrWr = we & mmioSel & (mmioOff == OFF_CLR) & wdata[0];

    assign fifoFull   = (count == CNT_FULL);
    assign fifoEmpty  = (count == '0);
    assign out_valid  = ~fifoEmpty;
    assign pop        = out_valid & out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign pushAccept = push & (~fifoFull | pop);

    assign out_data = fifoEmpty ? '0 : fifoMem[rdPtr];

    assign countExt   = 32'(count);
    assign statusWord = {26'b0, overflow, fifoFull, fifoEmpty, countExt[2:0]};

    // RAM and FIFO storage: data only, never reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ramMem[ramIdx] <= wdata;
        end
        if (pushAccept) begin
            fifoMem[wrPtr] <= wdata;
        end
    end

    // FIFO control state
    always_ff @(posedge clk or negedge NReset) begin
        if (!NReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({pushAccept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A dropped push wins over a clear in the same cycle.
            if (push & fifoFull & ~pop) begin
                overflow <= 1'b1;
            end else if (clrWr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_CYCLE_CTR_EN
    always_ff @(posedge clk or negedge NReset) begin
        if (!NReset) begin
            cycleCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
        end
    end
`else
    assign cycleCnt = '0;
`endif

    // Load path: same-cycle read; MMIO reads are forced to 0 while in reset
    always_comb begin
        rdata = '0;
        if (!mmioSel) begin
            rdata = ramMem[ramIdx];
        end else if (NReset) begin
            case (mmioOff)
                OFF_STATUS: rdata = statusWord;
                OFF_CYCLE:  rdata = cycleCnt;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp: RAM, stream FIFO, overflow, reset and counter.
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        NReset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    int nCmp = 0;
    int nErr = 0;

    localparam logic [31:0] A_OUTQ   = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0001;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0002;
    localparam logic [31:0] A_CLR    = 32'h8000_0003;

`ifdef DMEM_CYCLE_CTR_EN
    localparam logic [31:0] CYC3 = 32'd3;
`else
    localparam logic [31:0] CYC3 = 32'd0;
`endif

    data_mem_resp #(.DEPTH_LOG2(8), .FIFO_LOG2(2)) dut (
        .clk(clk),
        .NReset(NReset),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .rdata(rdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic popCheck(input string tag, input logic [31:0] exp);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, out_data, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        NReset    = 1'b0;
        out_ready = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rd("rst_status_rd", A_STATUS, 32'd0);

        @(negedge clk);
        NReset = 1'b1;
        rd("status_idle", A_STATUS, 32'h08);
        rd("cycle_0", A_CYCLE, 32'd0);
        repeat (3) @(posedge clk);
        rd("cycle_3", A_CYCLE, CYC3);

        // RAM store/load and aliasing
        wr(32'h0000_0005, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0005, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0105, 32'hDEAD_BEEF);
        addr  = 32'h0000_0005;
        wdata = 32'h1234_5678;
        we    = 1'b1;
        #1;
        check("ram_rdw_old", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd("ram_rdw_new", 32'h0000_0005, 32'h1234_5678);
        rd("outq_rd", A_OUTQ, 32'd0);
        rd("unmapped_rd", 32'h8000_0005, 32'd0);

        // Stream order
        wr(A_OUTQ, 32'h11);
        check("push1_valid", 32'(out_valid), 32'd1);
        check("push1_head", out_data, 32'h11);
        wr(A_OUTQ, 32'h22);
        wr(A_OUTQ, 32'h33);
        rd("status_3", A_STATUS, 32'h03);
        @(posedge clk);
        #1;
        check("head_stable", out_data, 32'h11);
        out_ready = 1'b1;
        popCheck("pop_11", 32'h11);
        popCheck("pop_22", 32'h22);
        popCheck("pop_33", 32'h33);
        out_ready = 1'b0;
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_data", out_data, 32'd0);

        // Overflow: fifth push dropped
        wr(A_OUTQ, 32'hA1);
        wr(A_OUTQ, 32'hA2);
        wr(A_OUTQ, 32'hA3);
        wr(A_OUTQ, 32'hA4);
        rd("status_full", A_STATUS, 32'h14);
        wr(A_OUTQ, 32'hA5);
        check("ovf_set", 32'(overflow), 32'd1);
        rd("status_ovf", A_STATUS, 32'h34);
        wr(A_CLR, 32'd0);
        check("clr0_keeps", 32'(overflow), 32'd1);
        wr(A_CLR, 32'd1);
        check("clr1_clears", 32'(overflow), 32'd0);
        rd("status_clr", A_STATUS, 32'h14);

        // Push and pop together while full
        addr      = A_OUTQ;
        wdata     = 32'h55;
        we        = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        we        = 1'b0;
        out_ready = 1'b0;
        check("pp_ovf", 32'(overflow), 32'd0);
        rd("pp_status", A_STATUS, 32'h14);
        check("pp_head", out_data, 32'hA2);
        out_ready = 1'b1;
        popCheck("pop_A2", 32'hA2);
        popCheck("pop_A3", 32'hA3);
        popCheck("pop_A4", 32'hA4);
        popCheck("pop_55", 32'h55);
        out_ready = 1'b0;
        check("no_A5", 32'(out_valid), 32'd0);

        // Reset mid-stream
        wr(A_OUTQ, 32'h66);
        wr(A_OUTQ, 32'h77);
        rd("status_2", A_STATUS, 32'h02);
        #2;
        NReset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", out_data, 32'd0);
        rd("midrst_status_rd", A_STATUS, 32'd0);
        NReset = 1'b1;
        rd("midrst_status", A_STATUS, 32'h08);
        rd("midrst_cycle", A_CYCLE, 32'd0);
        rd("ram_kept", 32'h0000_0005, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
